// File: rtl/spi_programmer.sv
// spi_programmer: SPI-slave loader for the non-volatile memory programmer port.
// Receives {addr,data} frames, issues one pwe per frame, holds the CPU in reset.
//
// Ports:
//   clk        system clock
//   reset      asynchronous active-high reset
//   sck        SPI clock from host (mode 0, async to clk)
//   mosi       SPI data from host, MSB first
//   cs_n       SPI chip select, active low, async
//   paddr      programming word address (held until next write)
//   pdata      programming write data (held until next write)
//   pwe        single-cycle write strobe
//   cpu_reset  registered CPU reset request
//   prog_busy  high whenever the FSM is not IDLE
//   frame_err  sticky truncated-frame flag
//   wcount     frames written since reset, wrapping
module spi_programmer #(
    parameter int SYNC_STAGES = 2,
    parameter int ADDR_W      = 16,
    parameter int DATA_W      = 32,
    parameter int RST_HOLD    = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sck,
    input  logic              mosi,
    input  logic              cs_n,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pdata,
    output logic              pwe,
    output logic              cpu_reset,
    output logic              prog_busy,
    output logic              frame_err,
    output logic [15:0]       wcount
);

    localparam int FW = ADDR_W + DATA_W;
    localparam int BW = $clog2(FW);
    localparam int CW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

    localparam logic [BW-1:0] LAST_BIT  = BW'(FW - 1);
    localparam logic [CW-1:0] HOLD_INIT = CW'(RST_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        WRITE,
        RELEASE
    } state_t;

    // Synchronisers. cs_n idles high so its chain resets to 1, which keeps
    // a reset release from looking like a chip-select edge.
    logic [SYNC_STAGES-1:0] sck_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] csn_sync_q;
    logic                   sck_d_q;
    logic                   csn_d_q;

    logic sck_s;
    logic mosi_s;
    logic csn_s;
    logic sck_rise;
    logic cs_fall;
    logic cs_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            csn_sync_q  <= '1;
            sck_d_q     <= 1'b0;
            csn_d_q     <= 1'b1;
        end else begin
            sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], sck};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], mosi};
            csn_sync_q  <= {csn_sync_q[SYNC_STAGES-2:0], cs_n};
            sck_d_q     <= sck_s;
            csn_d_q     <= csn_s;
        end
    end

    assign sck_s    = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
    assign csn_s    = csn_sync_q[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d_q;
    assign cs_fall  = csn_d_q & ~csn_s;
    assign cs_rise  = ~csn_d_q & csn_s;

    // Main FSM and datapath
    state_t            state_q,   state_d;
    logic [CW-1:0]     hold_q,    hold_d;
    logic [BW-1:0]     bitcnt_q,  bitcnt_d;
    logic [FW-1:0]     sr_q,      sr_d;
    logic [ADDR_W-1:0] paddr_q,   paddr_d;
    logic [DATA_W-1:0] pdata_q,   pdata_d;
    logic              pwe_q,     pwe_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              ferr_q,    ferr_d;
    logic [15:0]       wcount_q,  wcount_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RELEASE;
            hold_q    <= HOLD_INIT;
            bitcnt_q  <= '0;
            sr_q      <= '0;
            paddr_q   <= '0;
            pdata_q   <= '0;
            pwe_q     <= 1'b0;
            cpu_rst_q <= 1'b1;
            ferr_q    <= 1'b0;
            wcount_q  <= '0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            bitcnt_q  <= bitcnt_d;
            sr_q      <= sr_d;
            paddr_q   <= paddr_d;
            pdata_q   <= pdata_d;
            pwe_q     <= pwe_d;
            cpu_rst_q <= cpu_rst_d;
            ferr_q    <= ferr_d;
            wcount_q  <= wcount_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        sr_d     = sr_q;
        paddr_d  = paddr_q;
        pdata_d  = pdata_q;
        pwe_d    = 1'b0;
        ferr_d   = ferr_q;
        wcount_d = wcount_q;
        // Outside RELEASE the counter sits at its load value, so entering
        // RELEASE from any state starts a full hold.
        hold_d   = HOLD_INIT;

        unique case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d  = SHIFT;
                    bitcnt_d = '0;
                end
            end

            SHIFT: begin
                // A chip-select rise outranks a coincident sck rise.
                if (cs_rise) begin
                    if (bitcnt_q != '0) begin
                        ferr_d = 1'b1;
                    end
                    bitcnt_d = '0;
                    sr_d     = '0;
                    state_d  = RELEASE;
                end else if (sck_rise) begin
                    sr_d = {sr_q[FW-2:0], mosi_s};
                    if (bitcnt_q == LAST_BIT) begin
                        bitcnt_d = '0;
                        state_d  = WRITE;
                    end else begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
            end

            WRITE: begin
                {paddr_d, pdata_d} = sr_q;
                pwe_d    = 1'b1;
                wcount_d = wcount_q + 16'd1;
                // Level test, so a cs_n rise landing in this cycle still
                // completes the write and then releases.
                state_d  = csn_s ? RELEASE : SHIFT;
            end

            RELEASE: begin
                hold_d = hold_q;
                if (cs_fall) begin
                    state_d  = SHIFT;
                    bitcnt_d = '0;
                end else if (hold_q == '0) begin
                    state_d = IDLE;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end

            default: begin
                state_d = RELEASE;
            end
        endcase

        cpu_rst_d = (state_d != IDLE);
    end

    assign paddr     = paddr_q;
    assign pdata     = pdata_q;
    assign pwe       = pwe_q;
    assign cpu_reset = cpu_rst_q;
    assign prog_busy = (state_q != IDLE);
    assign frame_err = ferr_q;
    assign wcount    = wcount_q;

endmodule
